// File: rtl/alu_execute_if.sv
// Opcode encodings and the request/response bundle between ALU control and the execute stage.
package alu_execute_pkg;
  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_AND = 4'h2;
  localparam logic [3:0] OP_OR  = 4'h3;
  localparam logic [3:0] OP_XOR = 4'h4;
  localparam logic [3:0] OP_LSL = 4'h5;
  localparam logic [3:0] OP_LSR = 4'h6;
  localparam logic [3:0] OP_CSL = 4'h7;
  localparam logic [3:0] OP_CSR = 4'h8;
  localparam logic [3:0] OP_ASR = 4'h9;
endpackage

interface alu_execute_if #(parameter int WORD_WIDTH = 32) ();
  logic                  in_valid;
  logic                  in_ready;
  logic [WORD_WIDTH-1:0] alu_a;
  logic [WORD_WIDTH-1:0] alu_b;
  logic                  alu_ic;
  logic [3:0]            alu_opcode;
  logic                  store_carry;
  logic                  store_overflow;
  logic                  flush;
  logic                  out_valid;
  logic                  out_ready;
  logic [WORD_WIDTH-1:0] result;
  logic                  carry;
  logic                  overflow;

  modport master (
    output in_valid, alu_a, alu_b, alu_ic, alu_opcode, store_carry, store_overflow, flush, out_ready,
    input  in_ready, out_valid, result, carry, overflow
  );
  modport slave (
    input  in_valid, alu_a, alu_b, alu_ic, alu_opcode, store_carry, store_overflow, flush, out_ready,
    output in_ready, out_valid, result, carry, overflow
  );
endinterface

// File: rtl/alu_execute.sv
// Execute stage: single-cycle arithmetic/logic ops, iterative one-bit-per-cycle shifts,
// result held in DONE until consumed; carry/overflow are sticky architectural flags.
module alu_execute
  import alu_execute_pkg::*;
#(
  parameter int WORD_WIDTH = 32
) (
  input  logic         clk,
  input  logic         reset,
  alu_execute_if.slave bus
);
  localparam int W  = WORD_WIDTH;
  localparam int SW = $clog2(WORD_WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t          r_state;
  state_t          w_nxt;
  logic [W-1:0]    r_result;
  logic            r_carry;
  logic            r_ovf;
  logic [SW-1:0]   r_cnt;
  logic [3:0]      r_op;
  logic            r_st_c;
  logic            r_st_v;

  logic            w_acc;
  logic            w_is_shift;
  logic [SW-1:0]   w_k;
  logic [W:0]      w_sum;
  logic [W-1:0]    w_res;
  logic            w_c;
  logic            w_v;
  logic [W-1:0]    w_step;

  assign w_k        = bus.alu_a[SW-1:0];
  assign w_is_shift = (bus.alu_opcode == OP_LSL) || (bus.alu_opcode == OP_LSR) ||
                      (bus.alu_opcode == OP_CSL) || (bus.alu_opcode == OP_CSR) ||
                      (bus.alu_opcode == OP_ASR);

  // Shift ops pass alu_b through here; it becomes the seed for the iterative shifter.
  always_comb begin
    w_sum = {1'b0, bus.alu_b} + {1'b0, bus.alu_a} + {{W{1'b0}}, bus.alu_ic};
    w_res = bus.alu_b;
    w_c   = 1'b0;
    w_v   = 1'b0;
    case (bus.alu_opcode)
      OP_ADD: begin
        w_res = w_sum[W-1:0];
        w_c   = w_sum[W];
        w_v   = (bus.alu_a[W-1] == bus.alu_b[W-1]) && (w_sum[W-1] != bus.alu_b[W-1]);
      end
      OP_AND:  w_res = bus.alu_b & bus.alu_a;
      OP_OR:   w_res = bus.alu_b | bus.alu_a;
      OP_XOR:  w_res = bus.alu_b ^ bus.alu_a;
      default: w_res = bus.alu_b;
    endcase
  end

  always_comb begin
    w_step = r_result;
    case (r_op)
      OP_LSL:  w_step = {r_result[W-2:0], 1'b0};
      OP_LSR:  w_step = {1'b0, r_result[W-1:1]};
      OP_CSL:  w_step = {r_result[W-2:0], r_result[W-1]};
      OP_CSR:  w_step = {r_result[0], r_result[W-1:1]};
      OP_ASR:  w_step = {r_result[W-1], r_result[W-1:1]};
      default: w_step = r_result;
    endcase
  end

  always_comb begin
    w_nxt = r_state;
    w_acc = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.in_valid && !bus.flush) begin
          w_acc = 1'b1;
          w_nxt = (w_is_shift && (w_k != '0)) ? S_SHIFT : S_DONE;
        end
      end
      S_SHIFT: if (r_cnt == SW'(1)) w_nxt = S_DONE;
      S_DONE:  if (bus.out_ready) w_nxt = S_IDLE;
      default: w_nxt = S_IDLE;
    endcase
    if (bus.flush) w_nxt = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_nxt;
  end

  // Flags load only on the edge entering DONE, so an aborted op never touches them.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_result <= '0;
      r_carry  <= 1'b0;
      r_ovf    <= 1'b0;
      r_cnt    <= '0;
      r_op     <= OP_NOP;
      r_st_c   <= 1'b0;
      r_st_v   <= 1'b0;
    end else if (w_acc) begin
      r_op     <= bus.alu_opcode;
      r_st_c   <= bus.store_carry;
      r_st_v   <= bus.store_overflow;
      r_result <= w_res;
      r_cnt    <= w_is_shift ? w_k : '0;
      if (!(w_is_shift && (w_k != '0))) begin
        if (bus.store_carry)    r_carry <= w_c;
        if (bus.store_overflow) r_ovf   <= w_v;
      end
    end else if ((r_state == S_SHIFT) && !bus.flush) begin
      r_result <= w_step;
      r_cnt    <= r_cnt - 1'b1;
      if (r_cnt == SW'(1)) begin
        if (r_st_c) r_carry <= 1'b0;
        if (r_st_v) r_ovf   <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = (r_state == S_IDLE);
  assign bus.out_valid = (r_state == S_DONE);
  assign bus.result    = r_result;
  assign bus.carry     = r_carry;
  assign bus.overflow  = r_ovf;
endmodule

// File: tb/tb_alu_execute.sv
// Directed bench for alu_execute: reference model feeds a scoreboard, DONE outputs are popped and compared.
module tb_alu_execute;
  import alu_execute_pkg::*;

  typedef struct {
    logic [31:0] r;
    logic        c;
    logic        v;
    int          lat;
  } exp_t;

  logic clk;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  logic m_c = 1'b0;
  logic m_v = 1'b0;
  exp_t sb[$];

  alu_execute_if #(.WORD_WIDTH(32)) bus ();
  alu_execute #(.WORD_WIDTH(32)) dut (.clk(clk), .reset(reset), .bus(bus.slave));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit exceeded");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input logic ic, input logic sc, input logic so);
    exp_t        e;
    logic [32:0] s;
    logic        cc, vv;
    int          k;
    k  = int'(a[4:0]);
    cc = 1'b0;
    vv = 1'b0;
    e.lat = 1;
    case (op)
      OP_ADD: begin
        s   = {1'b0, b} + {1'b0, a} + {32'd0, ic};
        e.r = s[31:0];
        cc  = s[32];
        vv  = (a[31] == b[31]) && (s[31] != b[31]);
      end
      OP_AND: e.r = b & a;
      OP_OR:  e.r = b | a;
      OP_XOR: e.r = b ^ a;
      OP_LSL: begin e.r = b << k; e.lat = 1 + k; end
      OP_LSR: begin e.r = b >> k; e.lat = 1 + k; end
      OP_CSL: begin e.r = (k == 0) ? b : ((b << k) | (b >> (32 - k))); e.lat = 1 + k; end
      OP_CSR: begin e.r = (k == 0) ? b : ((b >> k) | (b << (32 - k))); e.lat = 1 + k; end
      OP_ASR: begin e.r = $unsigned($signed(b) >>> k); e.lat = 1 + k; end
      default: e.r = b;
    endcase
    if (sc) m_c = cc;
    if (so) m_v = vv;
    e.c = m_c;
    e.v = m_v;
    return e;
  endfunction

  task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic ic, input logic sc, input logic so);
    bus.in_valid       = 1'b1;
    bus.alu_opcode     = op;
    bus.alu_a          = a;
    bus.alu_b          = b;
    bus.alu_ic         = ic;
    bus.store_carry    = sc;
    bus.store_overflow = so;
  endtask

  // Scramble the operand bus after accept so that any late sampling shows up as a wrong result.
  task automatic scramble();
    bus.in_valid       = 1'b0;
    bus.alu_opcode     = 4'($urandom_range(0, 15));
    bus.alu_a          = $urandom;
    bus.alu_b          = $urandom;
    bus.alu_ic         = 1'($urandom_range(0, 1));
    bus.store_carry    = 1'b1;
    bus.store_overflow = 1'b1;
  endtask

  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic ic, input logic sc, input logic so,
                        input int hold);
    exp_t e;
    exp_t g;
    int   lat;
    sb.push_back(model(op, a, b, ic, sc, so));
    @(negedge clk);
    chk({tag, ".in_ready_idle"}, 32'(bus.in_ready), 32'd1);
    drive(op, a, b, ic, sc, so);
    bus.out_ready = (hold == 0);
    @(posedge clk);
    #1 scramble();
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (bus.out_valid !== 1'b1 && lat < 100);
    g = sb.pop_front();
    chk({tag, ".latency"}, 32'(lat), 32'(g.lat));
    chk({tag, ".result"}, bus.result, g.r);
    chk({tag, ".carry"}, 32'(bus.carry), 32'(g.c));
    chk({tag, ".overflow"}, 32'(bus.overflow), 32'(g.v));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({tag, ".hold_valid"}, 32'(bus.out_valid), 32'd1);
      chk({tag, ".hold_in_ready"}, 32'(bus.in_ready), 32'd0);
      chk({tag, ".hold_result"}, bus.result, g.r);
      chk({tag, ".hold_flags"}, {30'd0, bus.carry, bus.overflow}, {30'd0, g.c, g.v});
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk({tag, ".consumed_in_ready"}, 32'(bus.in_ready), 32'd1);
    chk({tag, ".consumed_valid"}, 32'(bus.out_valid), 32'd0);
    e = g;
  endtask

  // LSL k=8 aborted three cycles after accept, by flush or by reset.
  task automatic abort_shift(input string tag, input logic use_reset);
    int seen;
    @(negedge clk);
    drive(OP_LSL, 32'h8, 32'h1, 1'b0, 1'b1, 1'b1);
    @(posedge clk);
    #1 scramble();
    repeat (2) @(negedge clk);
    @(negedge clk);
    if (use_reset) reset = 1'b1;
    else           bus.flush = 1'b1;
    @(posedge clk);
    #1;
    reset     = 1'b0;
    bus.flush = 1'b0;
    if (use_reset) begin
      m_c = 1'b0;
      m_v = 1'b0;
    end
    @(negedge clk);
    chk({tag, ".in_ready"}, 32'(bus.in_ready), 32'd1);
    chk({tag, ".flags"}, {30'd0, bus.carry, bus.overflow}, {30'd0, m_c, m_v});
    if (use_reset) chk({tag, ".result_zero"}, bus.result, 32'd0);
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus.out_valid === 1'b1) seen++;
    end
    chk({tag, ".no_out_valid"}, 32'(seen), 32'd0);
  endtask

  initial begin
    exp_t e;
    int   seen;
    reset              = 1'b1;
    bus.in_valid       = 1'b0;
    bus.alu_a          = '0;
    bus.alu_b          = '0;
    bus.alu_ic         = 1'b0;
    bus.alu_opcode     = OP_NOP;
    bus.store_carry    = 1'b0;
    bus.store_overflow = 1'b0;
    bus.flush          = 1'b0;
    bus.out_ready      = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("reset.in_ready", 32'(bus.in_ready), 32'd1);
    chk("reset.out_valid", 32'(bus.out_valid), 32'd0);
    chk("reset.result", bus.result, 32'd0);
    chk("reset.carry", 32'(bus.carry), 32'd0);
    chk("reset.overflow", 32'(bus.overflow), 32'd0);

    run_op("add_wrap",    OP_ADD, 32'h1, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b1, 0);
    run_op("add_ovf",     OP_ADD, 32'h1, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b1, 0);
    run_op("add_nostore", OP_ADD, 32'h1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 0);
    run_op("add_ic",      OP_ADD, 32'h3, 32'h5,         1'b1, 1'b1, 1'b1, 0);
    run_op("add_both",    OP_ADD, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b1, 1'b1, 0);
    run_op("and",         OP_AND, 32'hF0F0_1234, 32'hFF00_FF0F, 1'b1, 1'b1, 1'b0, 0);
    run_op("or",          OP_OR,  32'h0F0F_0000, 32'h1234_5678, 1'b0, 1'b0, 1'b1, 0);
    run_op("xor",         OP_XOR, 32'hAAAA_5555, 32'hFFFF_0000, 1'b0, 1'b0, 1'b0, 0);
    run_op("nop",         OP_NOP, 32'hDEAD_BEEF, 32'hCAFE_F00D, 1'b1, 1'b0, 1'b0, 0);
    run_op("unknown",     4'hF,   32'h1234_0000, 32'h0BAD_0BAD, 1'b1, 1'b0, 1'b0, 0);
    run_op("lsl_k4",      OP_LSL, 32'h24, 32'h1, 1'b0, 1'b0, 1'b0, 0);
    run_op("csr_k1",      OP_CSR, 32'h1,  32'h1, 1'b0, 1'b0, 1'b0, 0);
    run_op("asr_k31",     OP_ASR, 32'h1F, 32'h8000_0000, 1'b0, 1'b0, 1'b0, 0);
    run_op("csl_k4",      OP_CSL, 32'h4,  32'h8000_0001, 1'b0, 1'b0, 1'b0, 0);
    run_op("lsr_k28",     OP_LSR, 32'h3C, 32'hF000_0000, 1'b0, 1'b0, 1'b0, 0);
    run_op("lsl_k0",      OP_LSL, 32'h20, 32'h8765_4321, 1'b0, 1'b0, 1'b0, 0);
    run_op("bp_add",      OP_ADD, 32'h1, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b1, 3);
    run_op("bp_lsr",      OP_LSR, 32'h3, 32'h0000_0F00, 1'b0, 1'b0, 1'b0, 3);
    run_op("shift_store", OP_LSL, 32'h2, 32'h3, 1'b0, 1'b1, 1'b1, 0);

    run_op("set_flags",   OP_ADD, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b1, 1'b1, 0);
    abort_shift("flush_shift", 1'b0);
    abort_shift("reset_shift", 1'b1);

    // Flush in DONE: the flags loaded on entering DONE survive, the result is dropped.
    e = model(OP_ADD, 32'h1, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    drive(OP_ADD, 32'h1, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b1);
    bus.out_ready = 1'b0;
    @(posedge clk);
    #1 scramble();
    @(negedge clk);
    chk("flush_done.valid", 32'(bus.out_valid), 32'd1);
    chk("flush_done.result", bus.result, e.r);
    bus.flush = 1'b1;
    @(posedge clk);
    #1 bus.flush = 1'b0;
    @(negedge clk);
    bus.out_ready = 1'b1;
    chk("flush_done.dropped", 32'(bus.out_valid), 32'd0);
    chk("flush_done.in_ready", 32'(bus.in_ready), 32'd1);
    chk("flush_done.flags", {30'd0, bus.carry, bus.overflow}, {30'd0, e.c, e.v});

    // Flush beats accept in the same cycle.
    @(negedge clk);
    drive(OP_ADD, 32'h1, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b1);
    bus.flush = 1'b1;
    @(posedge clk);
    #1;
    scramble();
    bus.flush = 1'b0;
    seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus.out_valid === 1'b1) seen++;
    end
    chk("flush_accept.no_valid", 32'(seen), 32'd0);
    chk("flush_accept.flags", {30'd0, bus.carry, bus.overflow}, {30'd0, m_c, m_v});

    run_op("recover",     OP_XOR, 32'h0000_FFFF, 32'h1234_5678, 1'b0, 1'b1, 1'b1, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
